minibyte_regmux: RTL and testbench
==================================

Name: minibyte_regmux

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. Generalises the existing combinational 2:1 byte mux. Adds:
- output pipeline register,
- backpressure,
- a run-time selectable arbitration mode: externally steered select, or fair round-robin.

It sits between multiple minibyte data sources (ALU, memory read, immediate, I/O) and a single consumer bus.

Parameters:
WIDTH, 8, data width per channel in bits
CHANNELS, 4, number of input channels (2..16, need not be a power of two)
SELW, $clog2(CHANNELS), width of the select and channel-id fields (derived; do not override)

Ports:
clk_in  input  1  system clock; all state updates on the rising edge
rst_in  input  1  synchronous reset, active-high
data_in  input  CHANNELS*WIDTH  channel data; channel i is bits [i*WIDTH +: WIDTH]
valid_in  input  CHANNELS  per-channel data valid
ready_out  output  CHANNELS  per-channel accept (one-hot or zero)
sel_in  input  SELW  channel select, used when mode_in=0
mode_in  input  1  0 = fixed select, 1 = round-robin
data_out  output  WIDTH  registered output data
chan_out  output  SELW  id of the channel that supplied data_out
valid_out  output  1  output holds valid data
ready_in  input  1  consumer accepts data_out this cycle

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - data_out=0, chan_out=0, valid_out=0.
  - Round-robin pointer last_q=CHANNELS-1, so channel 0 has first priority.
  - Reset wins over any simultaneous transfer.
  - Asserting reset mid-operation discards the held word.
- ready_out is 0 for all channels while rst_in=1.
- slot_free = !valid_out || ready_in (combinational).
- Fixed mode (mode_in=0):
  - cand = sel_in.
  - grant = slot_free && sel_in<CHANNELS && valid_in[sel_in].
  - sel_in >= CHANNELS produces no grant and no error.
- Round-robin mode (mode_in=1):
  - cand is the first i with valid_in[i]=1, searching last_q+1, last_q+2, ... modulo CHANNELS (wraps at CHANNELS-1 to 0).
  - grant = slot_free && any valid.
- ready_out[cand] = grant; all other ready_out bits are 0. ready_out never depends on ready_out itself, so there is no combinational loop.
- Input transfer occurs on a rising edge when ready_out[i] && valid_in[i]. On that edge:
  - data_out <= channel i data
  - chan_out <= i
  - valid_out <= 1
  - last_q <= i, in round-robin mode only; last_q is unchanged in fixed mode.
- Output transfer occurs when valid_out && ready_in. If no input transfer happens on the same edge, valid_out <= 0 and data_out/chan_out hold their last values.
- Simultaneous output and input transfer: the new word replaces the old one in the same cycle. Throughput is 1 word/cycle; latency is 1 cycle from input transfer to valid_out.
- Stall (valid_out && !ready_in): data_out, chan_out and valid_out stay stable; all ready_out bits are 0.
- mode_in and sel_in are sampled combinationally each cycle. Changing them never alters a word already in the output register.
- Round-robin fairness: with all channels continuously valid and ready_in=1, grants rotate 0,1,...,CHANNELS-1,0 with no channel skipped.

Decomposition:
- Shared package minibyte_pkg holds:
  - MB_DATA_W=8
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - default CHANNELS
- Sub-module minibyte_rr_arbiter (CHANNELS parameter):
  - inputs: request vector, last_q, enable
  - outputs: one-hot grant and grant index
  - purely combinational; the pointer register stays in minibyte_regmux.
- Output register and fixed-select decode live in the top module.

Test Plan:
1. Reset and idle: hold rst_in=1 for 2 cycles with all valid_in=1 -> valid_out=0, data_out=0, chan_out=0, ready_out=0000. Release with nothing valid -> outputs stay at reset values.
2. Fixed select with stall (mode_in=0, sel_in=2, ch2 data=0xA5, ready_in=0):
   - Cycle after the transfer: data_out=0xA5, chan_out=2, valid_out=1.
   - Following cycles: ready_out=0000 and outputs stable until ready_in=1.
   - Set sel_in=3 during the stall -> data_out remains 0xA5.
3. Round-robin rotation (mode_in=1, all valid, data ch i=0x10+i, ready_in=1 constant) -> data_out sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, valid_out held 1.
4. Round-robin skip and wrap: only ch1 and ch3 valid, last_q=3 after reset sequence -> grants 1,3,1,3. Then drop ch1 -> grants 3,3 with no gap cycles.
5. Out-of-range and non-power-of-two (CHANNELS=3, mode_in=0, sel_in=3) -> ready_out=000, valid_out stays 0. Then sel_in=0 -> ch0 accepted next edge.
6. Reset mid-operation: valid_out=1 under stall, assert rst_in for 1 cycle -> valid_out=0, data_out=0. First round-robin grant after reset goes to ch0.

Source files
------------

// File: rtl/minibyte_pkg.sv
// Shared constants for the minibyte register multiplexer family.
// Holds the data width, the arbitration mode encodings and the default channel count.
package minibyte_pkg;

  localparam int MB_DATA_W           = 8;
  localparam int MB_DEFAULT_CHANNELS = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/minibyte_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_q, wrapping at CHANNELS-1.
// The priority pointer itself is held by the instantiating module.
module minibyte_rr_arbiter
  import minibyte_pkg::*;
#(
  parameter int CHANNELS = MB_DEFAULT_CHANNELS,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     last_q,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx,
  output logic                any_req
);

  // One extra bit on the scan index so last_q+k can exceed CHANNELS-1 before wrapping.
  logic [SELW:0] scan_idx [CHANNELS];

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      scan_idx[k] = {1'b0, last_q} + (SELW+1)'(k + 1);
      if (scan_idx[k] >= (SELW+1)'(CHANNELS)) begin
        scan_idx[k] = scan_idx[k] - (SELW+1)'(CHANNELS);
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!any_req && req[scan_idx[k][SELW-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = scan_idx[k][SELW-1:0];
      end
    end
    if (enable && any_req) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/minibyte_regmux.sv
// N-channel registered multiplexer with valid/ready handshakes on every channel and the output.
// Channel choice is either steered by sel_in or made by a fair round-robin arbiter.
module minibyte_regmux
  import minibyte_pkg::*;
#(
  parameter int WIDTH    = MB_DATA_W,
  parameter int CHANNELS = MB_DEFAULT_CHANNELS,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_out,
  input  logic [SELW-1:0]           sel_in,
  input  logic                      mode_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [SELW-1:0]           chan_out,
  output logic                      valid_out,
  input  logic                      ready_in
);

  logic                slot_free;
  logic [SELW-1:0]     last_q;
  logic [CHANNELS-1:0] fixed_onehot;
  logic                fixed_valid;
  logic [CHANNELS-1:0] rr_grant;
  logic [SELW-1:0]     rr_idx;
  logic                rr_any;
  logic                rr_enable;
  logic [SELW-1:0]     cand;
  logic                grant;
  logic [WIDTH-1:0]    cand_data;

  assign slot_free = !valid_out || ready_in;

  // An out-of-range sel_in decodes to all zeros, so it can never produce a grant.
  always_comb begin
    fixed_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fixed_onehot[i] = (sel_in == SELW'(i));
    end
  end

  assign fixed_valid = |(fixed_onehot & valid_in);
  assign rr_enable   = !rst_in && slot_free && (mode_in == MODE_RR);

  minibyte_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_arbiter (
    .req       (valid_in),
    .last_q    (last_q),
    .enable    (rr_enable),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_req   (rr_any)
  );

  always_comb begin
    cand  = sel_in;
    grant = 1'b0;
    if (!rst_in && slot_free) begin
      if (mode_in == MODE_RR) begin
        cand  = rr_idx;
        grant = rr_any;
      end else begin
        grant = fixed_valid;
      end
    end else if (mode_in == MODE_RR) begin
      cand = rr_idx;
    end
  end

  always_comb begin
    ready_out = '0;
    if (mode_in == MODE_RR) begin
      ready_out = rr_grant;
    end else if (grant) begin
      ready_out = fixed_onehot;
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cand == SELW'(i)) begin
        cand_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // A new word may replace the outgoing one on the same edge, giving one word per cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out  <= '0;
      chan_out  <= '0;
      valid_out <= 1'b0;
      last_q    <= SELW'(CHANNELS - 1);
    end else if (grant) begin
      data_out  <= cand_data;
      chan_out  <= cand;
      valid_out <= 1'b1;
      if (mode_in == MODE_RR) begin
        last_q <= cand;
      end
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_minibyte_regmux.sv
// Directed self-checking bench for minibyte_regmux: a 4-channel instance plus a 3-channel one
// for the non-power-of-two select range and round-robin wrap.
module tb_minibyte_regmux;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  ready_out;
  logic [1:0]  sel_in;
  logic        mode_in;
  logic [7:0]  data_out;
  logic [1:0]  chan_out;
  logic        valid_out;
  logic        ready_in;

  logic        rst3;
  logic [23:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ready3_out;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  data3_out;
  logic [1:0]  chan3_out;
  logic        valid3_out;
  logic        ready3_in;

  int checks = 0;
  int errors = 0;

  minibyte_regmux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .sel_in    (sel_in),
    .mode_in   (mode_in),
    .data_out  (data_out),
    .chan_out  (chan_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  minibyte_regmux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk_in    (clk),
    .rst_in    (rst3),
    .data_in   (data3),
    .valid_in  (valid3),
    .ready_out (ready3_out),
    .sel_in    (sel3),
    .mode_in   (mode3),
    .data_out  (data3_out),
    .chan_out  (chan3_out),
    .valid_out (valid3_out),
    .ready_in  (ready3_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 4'b1111; mode_in = 1'b1; ready_in = 1'b1; sel_in = 2'd0;
    data_in = 32'h44332211;
    tick(); tick();
    checks++;
    if ({valid_out, data_out, chan_out} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h c=%0d expected v=0 d=00 c=0", valid_out, data_out, chan_out);
    end
    checks++;
    if (ready_out !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 0000", ready_out);
    end
    rst = 1'b0; valid_in = 4'b0000;
    tick(); tick();
    checks++;
    if ({valid_out, data_out, chan_out} !== 11'd0 || ready_out !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got v=%b d=%h c=%0d r=%b expected all zero", valid_out, data_out, chan_out, ready_out);
    end
  endtask

  task automatic test_fixed_stall();
    mode_in = 1'b0; sel_in = 2'd2; ready_in = 1'b0; valid_in = 4'b0100;
    data_in = 32'h33A51100;
    #1;
    checks++;
    if (ready_out !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL fixed_ready: got %b expected 0100", ready_out);
    end
    tick();
    checks++;
    if (data_out !== 8'hA5 || chan_out !== 2'd2 || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fixed_capture: got d=%h c=%0d v=%b expected d=a5 c=2 v=1", data_out, chan_out, valid_out);
    end
    data_in = 32'h335A1100; valid_in = 4'b1111; sel_in = 2'd3;
    #1;
    checks++;
    if (ready_out !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL stall_ready: got %b expected 0000", ready_out);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (data_out !== 8'hA5 || chan_out !== 2'd2 || valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold: got d=%h c=%0d v=%b expected d=a5 c=2 v=1", data_out, chan_out, valid_out);
      end
    end
    valid_in = 4'b0000; ready_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'hA5 || chan_out !== 2'd2) begin
      errors++;
      $display("[TB] FAIL drain_hold: got d=%h c=%0d v=%b expected d=a5 c=2 v=0", data_out, chan_out, valid_out);
    end
  endtask

  task automatic test_rr_rotation();
    logic [7:0] exp_data [5];
    exp_data[0] = 8'h10; exp_data[1] = 8'h11; exp_data[2] = 8'h12;
    exp_data[3] = 8'h13; exp_data[4] = 8'h10;
    mode_in = 1'b1; ready_in = 1'b1; valid_in = 4'b1111;
    data_in = 32'h13121110;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (data_out !== exp_data[n] || valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_rotation[%0d]: got d=%h v=%b expected d=%h v=1", n, data_out, valid_out, exp_data[n]);
      end
    end
    valid_in = 4'b0000;
    tick();
  endtask

  task automatic test_rr_skip_wrap();
    logic [1:0] exp_chan [6];
    exp_chan[0] = 2'd1; exp_chan[1] = 2'd3; exp_chan[2] = 2'd1;
    exp_chan[3] = 2'd3; exp_chan[4] = 2'd3; exp_chan[5] = 2'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0; mode_in = 1'b1; ready_in = 1'b1; valid_in = 4'b1010;
    data_in = 32'h43424140;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (chan_out !== exp_chan[n] || valid_out !== 1'b1 || data_out !== 8'h40 + 8'(exp_chan[n])) begin
        errors++;
        $display("[TB] FAIL rr_skip[%0d]: got c=%0d d=%h v=%b expected c=%0d v=1", n, chan_out, data_out, valid_out, exp_chan[n]);
      end
      if (n == 3) valid_in = 4'b1000;
    end
    valid_in = 4'b0000;
    tick();
  endtask

  task automatic test_out_of_range();
    rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; ready3_in = 1'b1;
    data3 = 24'h2B2A3C;
    tick();
    rst3 = 1'b0;
    #1;
    checks++;
    if (ready3_out !== 3'b000) begin
      errors++;
      $display("[TB] FAIL oor_ready: got %b expected 000", ready3_out);
    end
    tick(); tick();
    checks++;
    if (valid3_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_valid: got %b expected 0", valid3_out);
    end
    sel3 = 2'd0;
    #1;
    checks++;
    if (ready3_out !== 3'b001) begin
      errors++;
      $display("[TB] FAIL sel0_ready: got %b expected 001", ready3_out);
    end
    tick();
    checks++;
    if (data3_out !== 8'h3C || chan3_out !== 2'd0 || valid3_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sel0_capture: got d=%h c=%0d v=%b expected d=3c c=0 v=1", data3_out, chan3_out, valid3_out);
    end
  endtask

  task automatic test_rr_wrap3();
    logic [1:0] exp_chan [4];
    exp_chan[0] = 2'd0; exp_chan[1] = 2'd1; exp_chan[2] = 2'd2; exp_chan[3] = 2'd0;
    mode3 = 1'b1; valid3 = 3'b111; ready3_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (chan3_out !== exp_chan[n] || valid3_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_wrap3[%0d]: got c=%0d v=%b expected c=%0d v=1", n, chan3_out, valid3_out, exp_chan[n]);
      end
    end
    valid3 = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_op();
    mode_in = 1'b0; sel_in = 2'd1; valid_in = 4'b0010; ready_in = 1'b0;
    data_in = 32'h00007700;
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h77) begin
      errors++;
      $display("[TB] FAIL midop_load: got d=%h v=%b expected d=77 v=1", data_out, valid_out);
    end
    rst = 1'b1; mode_in = 1'b1; valid_in = 4'b1111; ready_in = 1'b1;
    data_in = 32'h23222120;
    #1;
    checks++;
    if (ready_out !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midop_reset_ready: got %b expected 0000", ready_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || chan_out !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got d=%h c=%0d v=%b expected d=00 c=0 v=0", data_out, chan_out, valid_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (chan_out !== 2'd0 || data_out !== 8'h20 || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_first_rr: got d=%h c=%0d v=%b expected d=20 c=0 v=1", data_out, chan_out, valid_out);
    end
  endtask

  initial begin
    rst3 = 1'b1; data3 = '0; valid3 = '0; sel3 = '0; mode3 = 1'b0; ready3_in = 1'b0;
    test_reset();
    test_fixed_stall();
    test_rr_rotation();
    test_rr_skip_wrap();
    test_out_of_range();
    test_rr_wrap3();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
